sysid_ext: RTL and testbench

Parametrised system-identification and uptime peripheral on the Qsys Avalon-MM bus, the successor to the two-word system ID slave. It returns compile-time ID, timestamp and version words, and adds a free-running 64-bit cycle counter with atomic snapshot reads, a seconds counter, a scratch register and a control/status register. Software uses it to check the FPGA image and to timestamp events.

---
 rtl/sysid_ext.sv | 134 +++++++++++++
 tb/tb_sysid_ext.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sysid_ext.sv
// sysid_ext -- system identification and uptime peripheral (Avalon-MM slave).
//
// Returns compile-time ID / build timestamp / version words. Also provides a
// free-running 64-bit cycle counter with a consistent LO/HI snapshot, a seconds
// counter driven by a clock-rate prescaler, a scratch word and a control word.
//
// Word map: 0 ID, 1 TIMESTAMP, 2 VERSION, 3 SCRATCH (RW, byte lanes),
//           4 UPTIME_LO (read latches HI into 5), 5 UPTIME_HI_SNAP,
//           6 SECONDS, 7 CTRL {SNAP_VALID, CLR (reads 0), EN}
//
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   address[2:0]   word address
//   read / write   access strobes
//   writedata[31:0], byteenable[3:0]  write data and its byte lanes
//   readdata[31:0] registered read data, zero unless readdatavalid
//   readdatavalid  one cycle after each read, fixed latency
//   sec_tick       one-cycle pulse following every SECONDS increment
module sysid_ext #(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
    parameter logic [31:0] VERSION_VALUE   = 32'h0001_0000,
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        sec_tick
);

    localparam int PRE_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);

    logic [31:0]      scratch;
    logic             en;
    logic [63:0]      uptime;
    logic [PRE_W-1:0] prescale;
    logic [31:0]      seconds;
    logic [31:0]      snap_hi;
    logic             snap_valid;

    logic             wr_scratch;
    logic             wr_ctrl;
    logic             clr;
    logic             rd_lo;
    logic             terminal;
    logic [31:0]      scratch_next;
    logic [31:0]      rd_mux;

    assign wr_scratch = write && (address == 3'd3);
    assign wr_ctrl    = write && (address == 3'd7);
    assign clr        = wr_ctrl && writedata[1];
    assign rd_lo      = read && (address == 3'd4);
    assign terminal   = en && (prescale == PRE_LAST);

    always_comb begin
        scratch_next = scratch;
        for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch_next[b*8 +: 8] = writedata[b*8 +: 8];
        end
    end

    // Read mux sees register state before this edge's writes, so a
    // simultaneous read and write returns the old value.
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0:    rd_mux = ID_VALUE;
            3'd1:    rd_mux = TIMESTAMP_VALUE;
            3'd2:    rd_mux = VERSION_VALUE;
            3'd3:    rd_mux = scratch;
            3'd4:    rd_mux = uptime[31:0];
            3'd5:    rd_mux = snap_hi;
            3'd6:    rd_mux = seconds;
            3'd7:    rd_mux = {29'd0, snap_valid, 1'b0, en};
            default: rd_mux = 32'd0;
        endcase
    end

    // Counters use the EN value held before this edge; a CTRL write changes EN
    // from the next edge on, while CLR overrides any increment on this edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch       <= 32'd0;
            en            <= 1'b1;
            uptime        <= 64'd0;
            prescale      <= '0;
            seconds       <= 32'd0;
            snap_hi       <= 32'd0;
            snap_valid    <= 1'b0;
            sec_tick      <= 1'b0;
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
        end else begin
            if (wr_scratch) scratch <= scratch_next;
            if (wr_ctrl)    en      <= writedata[0];

            if (clr) begin
                uptime     <= 64'd0;
                prescale   <= '0;
                seconds    <= 32'd0;
                snap_hi    <= 32'd0;
                snap_valid <= 1'b0;
                sec_tick   <= 1'b0;
            end else begin
                if (en) uptime <= uptime + 64'd1;
                if (terminal) begin
                    prescale <= '0;
                    seconds  <= seconds + 32'd1;
                end else if (en) begin
                    prescale <= prescale + PRE_W'(1);
                end
                sec_tick <= terminal;
                // HI is captured on the same edge that LO is sampled, so the
                // pair is coherent even across a carry out of bit 31.
                if (rd_lo) begin
                    snap_hi    <= uptime[63:32];
                    snap_valid <= 1'b1;
                end
            end

            readdatavalid <= read;
            readdata      <= read ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_sysid_ext.sv
// tb_sysid_ext -- directed-vector bench for sysid_ext with a 4 Hz prescaler.
module tb_sysid_ext;

    localparam logic [31:0] ID_V  = 32'h5A2D_FB50;
    localparam logic [31:0] TS_V  = 32'h6500_1234;
    localparam logic [31:0] VER_V = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        sec_tick;

    int n_vec = 0;
    int n_err = 0;

    sysid_ext #(
        .ID_VALUE        (ID_V),
        .TIMESTAMP_VALUE (TS_V),
        .VERSION_VALUE   (VER_V),
        .CLK_FREQ_HZ     (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .sec_tick      (sec_tick)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One read issued on the next edge; checks data and valid just after it.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0;
        check({tag, "_vld"}, 32'(readdatavalid), 32'd1);
        check(tag, readdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
    endtask

    initial begin
        // Reset state and the constant words
        do_reset();
        check("rst_rdata", readdata, 32'd0);
        check("rst_rvld", 32'(readdatavalid), 32'd0);
        check("rst_tick", 32'(sec_tick), 32'd0);
        rd(3'd0, ID_V, "id");
        rd(3'd1, TS_V, "timestamp");
        rd(3'd2, VER_V, "version");
        @(posedge clock);
        #1;
        check("rvld_one_cycle", 32'(readdatavalid), 32'd0);
        check("rdata_idle_zero", readdata, 32'd0);
        rd(3'd7, 32'h1, "ctrl_rst");
        rd(3'd3, 32'h0, "scratch_rst");

        // Scratch byte lanes, RO write ignore, read-during-write
        wr(3'd3, 32'hDEAD_BEEF, 4'hF);
        wr(3'd3, 32'h0000_0012, 4'b0001);
        rd(3'd3, 32'hDEAD_BE12, "scratch_be");
        wr(3'd3, 32'hAB00_0000, 4'b1000);
        rd(3'd3, 32'hABAD_BE12, "scratch_be3");
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        rd(3'd0, ID_V, "id_ro");
        @(negedge clock);
        address = 3'd3; writedata = 32'h1111_1111; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
        check("rw_old", readdata, 32'hABAD_BE12);
        rd(3'd3, 32'h1111_1111, "rw_new");

        // Snapshot coherence across a carry out of bit 31
        @(negedge clock);
        force dut.uptime = 64'h0000_0000_FFFF_FFFE;
        address = 3'd4;
        read    = 1'b1;
        @(posedge clock);
        #1;
        release dut.uptime;
        read = 1'b0;
        check("snap_lo", readdata, 32'hFFFF_FFFE);
        rd(3'd5, 32'h0, "snap_hi");
        rd(3'd7, 32'h5, "snap_valid");
        rd(3'd4, 32'h0, "carry_lo");
        rd(3'd5, 32'h1, "carry_hi");

        // 64-bit wrap
        @(negedge clock);
        force dut.uptime = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clock);
        #1;
        release dut.uptime;
        rd(3'd4, 32'hFFFF_FFFF, "wrap_lo_max");
        rd(3'd4, 32'h0, "wrap_lo_zero");
        rd(3'd5, 32'h0, "wrap_hi_zero");

        // Prescaler, seconds and EN freeze
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("tick_%0d", i), 32'(sec_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        rd(3'd6, 32'd3, "seconds_12");
        wr(3'd7, 32'h0, 4'hF);
        rd(3'd6, 32'd3, "seconds_frz");
        rd(3'd4, 32'd14, "uptime_frz");
        repeat (20) @(posedge clock);
        rd(3'd7, 32'h4, "ctrl_en0");
        rd(3'd6, 32'd3, "seconds_frz20");
        rd(3'd4, 32'd14, "uptime_frz20");
        wr(3'd7, 32'h1, 4'hF);
        rd(3'd4, 32'd14, "uptime_resume0");
        rd(3'd4, 32'd15, "uptime_resume1");

        // CLR on the terminal-count edge
        do_reset();
        repeat (3) @(posedge clock);
        wr(3'd7, 32'h3, 4'hF);
        check("clr_no_tick", 32'(sec_tick), 32'd0);
        rd(3'd7, 32'h1, "clr_ctrl");
        rd(3'd6, 32'd0, "clr_seconds");
        rd(3'd4, 32'd2, "clr_uptime");

        // Reset while a read is in flight
        wr(3'd3, 32'h0000_00A5, 4'hF);
        @(negedge clock);
        address = 3'd3;
        read    = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        read    = 1'b0;
        #1;
        check("mid_rst_rvld", 32'(readdatavalid), 32'd0);
        check("mid_rst_rdata", readdata, 32'd0);
        check("mid_rst_tick", 32'(sec_tick), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_rvld", 32'(readdatavalid), 32'd0);
        rd(3'd7, 32'h1, "post_rst_ctrl");
        rd(3'd3, 32'h0, "post_rst_scratch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
